puck_motion: RTL and testbench
==============================

// Module: puck_motion
// PURPOSE
//  Upstream of the puck draw_circle stage: owns puck position/velocity, advances once per frame.
//  Per frame: wall bounce, goal detection, player collision vs. player circle centre/radius.
//  xpos_out/ypos_out drive the puck draw_circle xpos_in/ypos_in; player_r_in from player radius_player.
// PARAMETERS
//  X_MIN      32    left table edge (px)
//  X_MAX      991   right table edge (px)
//  Y_MIN      32    top table edge (px)
//  Y_MAX      735   bottom table edge (px)
//  PUCK_R     12    puck radius (px)
//  GOAL_Y_LO  288   goal mouth top (inclusive)
//  GOAL_Y_HI  479   goal mouth bottom (inclusive)
//  START_X    512   centre spot x
//  START_Y    384   centre spot y
//  SERVE_VX   3     serve velocity x (px/frame, signed)
//  SERVE_VY   2     serve velocity y
//  VMAX       7     |velocity| saturation per axis
// PORTS
//  clk_in       in   1   pixel clock, single clock domain
//  rst          in   1   synchronous, active-high reset
//  vblnk_in     in   1   vertical blank from timing chain; rising edge = frame tick
//  serve_in     in   1   one-cycle serve request
//  player_x_in  in   12  player centre x
//  player_y_in  in   12  player centre y
//  player_r_in  in   8   player radius
//  xpos_out     out  12  puck centre x
//  ypos_out     out  12  puck centre y
//  goal_left    out  1   one-cycle pulse: puck entered left goal
//  goal_right   out  1   one-cycle pulse: puck entered right goal
//  in_play      out  1   high while puck moving
// BEHAVIOUR
//  Reset (sync, rst=1): xpos=START_X, ypos=START_Y, vx=vy=0, goal_*=0, in_play=0, state IDLE, tick reg=0.
//  Tick = vblnk_in high & registered vblnk_in low. Velocities signed 5-bit; position math signed 13-bit.
//  FSM: IDLE -> WAIT on serve_in (vx=SERVE_VX, vy=SERVE_VY, in_play=1); serve_in ignored elsewhere.
//  WAIT -> STEP_Y on tick. Ticks outside WAIT ignored (pipeline is 4 cycles, << vblank).
//  STEP_Y: ny=y+vy; ny-PUCK_R<Y_MIN -> ny=Y_MIN+PUCK_R, vy=-vy; ny+PUCK_R>Y_MAX -> ny=Y_MAX-PUCK_R, vy=-vy.
//  STEP_X: nx=x+vx; nx-PUCK_R<X_MIN: ny in [GOAL_Y_LO,GOAL_Y_HI] -> GOAL(left) else nx=X_MIN+PUCK_R, vx=-vx.
//    Right edge mirrored (nx+PUCK_R>X_MAX) -> GOAL(right) or reflect. Corner: both axes reflect same frame.
//  HIT_CALC: dx=nx-player_x, dy=ny-player_y; register d2=dx*dx+dy*dy (26b), lim=(PUCK_R+player_r)^2.
//  HIT_APPLY: d2<=lim -> vx=sat(dx>>>2,±VMAX), vy=sat(dy>>>2,±VMAX); both zero -> vx=+1.
//    Else velocity unchanged. Commit xpos_out=nx, ypos_out=ny; -> WAIT. Outputs change 4 cycles after tick.
//  GOAL: goal_left/right high exactly 1 cycle; x,y=START; vx=vy=0; in_play=0; -> IDLE.
//  Positions held stable between commits (draw stage sees constant values within a frame).
//  Reset mid-operation: next cycle all reset values; pending tick/serve discarded.
//  Player inputs sampled only in HIT_CALC; no handshake required upstream.
// STRUCTURE
//  air_hockey_pkg: table bounds, goal window, START_*, state encoding, velocity width constant.
//  Sub-module circle_hit_check: dx,dy,r_sum in -> registered d2<=lim flag (1-cycle latency), reusable by player-wall logic.
// TESTING
//  Reset, no serve, 3 ticks -> xpos=512, ypos=384, in_play=0, no goal pulses.
//  Serve, 1 tick -> 4 cycles later xpos=515, ypos=386; unchanged until next tick.
//  ypos=724, vy=+2, tick -> ypos=723, vy=-2; next tick ypos=721.
//  x=45, y=384, vx=-3, tick -> goal_left one cycle, x/y=512/384, in_play=0, IDLE.
//  x=45, y=100, vx=-3, tick -> xpos=44, vx=+3, no goal pulse.
//  Player at (540,386) r=20, puck (515,386) vx=3 -> hit: vx=sat(-22>>>2)=-6, vy=0.

Source files
------------

// File: rtl/air_hockey_pkg.sv
// Shared geometry, arithmetic widths and FSM encoding for the air-hockey puck logic.
package air_hockey_pkg;
    localparam int COORD_W = 12;
    localparam int MATH_W  = 13;
    localparam int VEL_W   = 5;
    localparam int D2_W    = 26;
    localparam int R_W     = 8;

    typedef logic signed [MATH_W-1:0] coord_s_t;
    typedef logic signed [VEL_W-1:0]  vel_t;

    localparam coord_s_t X_MIN_C     = 13'sd32;
    localparam coord_s_t X_MAX_C     = 13'sd991;
    localparam coord_s_t Y_MIN_C     = 13'sd32;
    localparam coord_s_t Y_MAX_C     = 13'sd735;
    localparam coord_s_t PUCK_R_C    = 13'sd12;
    localparam coord_s_t GOAL_Y_LO_C = 13'sd288;
    localparam coord_s_t GOAL_Y_HI_C = 13'sd479;
    localparam coord_s_t START_X_C   = 13'sd512;
    localparam coord_s_t START_Y_C   = 13'sd384;
    localparam vel_t     SERVE_VX_C  = 5'sd3;
    localparam vel_t     SERVE_VY_C  = 5'sd2;
    localparam vel_t     VMAX_C      = 5'sd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEP_Y,
        ST_STEP_X,
        ST_HIT_CALC,
        ST_HIT_APPLY,
        ST_GOAL
    } state_t;

    function automatic vel_t sat_vel(input coord_s_t v, input vel_t vmax);
        vel_t r;
        if (v > coord_s_t'(vmax)) begin
            r = vmax;
        end else if (v < -coord_s_t'(vmax)) begin
            r = -vmax;
        end else begin
            r = v[VEL_W-1:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/puck_motion_if.sv
// Frame timing, serve and player inputs plus puck position/event outputs of the puck mover.
interface puck_motion_if;
    logic                                vblnk_in;
    logic                                serve_in;
    logic [air_hockey_pkg::COORD_W-1:0]  player_x_in;
    logic [air_hockey_pkg::COORD_W-1:0]  player_y_in;
    logic [air_hockey_pkg::R_W-1:0]      player_r_in;
    logic [air_hockey_pkg::COORD_W-1:0]  xpos_out;
    logic [air_hockey_pkg::COORD_W-1:0]  ypos_out;
    logic                                goal_left;
    logic                                goal_right;
    logic                                in_play;

    modport master (
        output vblnk_in, serve_in, player_x_in, player_y_in, player_r_in,
        input  xpos_out, ypos_out, goal_left, goal_right, in_play
    );

    modport slave (
        input  vblnk_in, serve_in, player_x_in, player_y_in, player_r_in,
        output xpos_out, ypos_out, goal_left, goal_right, in_play
    );
endinterface

// File: rtl/circle_hit_check.sv
// Registered circle overlap test: flags dx^2 + dy^2 <= r_sum^2 one cycle after the inputs.
module circle_hit_check
    import air_hockey_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst,
    input  coord_s_t             dx_i,
    input  coord_s_t             dy_i,
    input  logic [R_W:0]         r_sum_i,
    output logic                 hit_o
);
    logic [MATH_W-1:0] adx;
    logic [MATH_W-1:0] ady;
    logic [D2_W-1:0]   d2;
    logic [D2_W-1:0]   lim;
    logic              hit_d;
    logic              hit_q;

    // Squaring magnitudes keeps the sum unsigned and inside 26 bits.
    assign adx   = dx_i[MATH_W-1] ? -dx_i : dx_i;
    assign ady   = dy_i[MATH_W-1] ? -dy_i : dy_i;
    assign d2    = D2_W'(adx) * D2_W'(adx) + D2_W'(ady) * D2_W'(ady);
    assign lim   = D2_W'(r_sum_i) * D2_W'(r_sum_i);
    assign hit_d = (d2 <= lim);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;
endmodule

// File: rtl/puck_motion.sv
// Puck position/velocity owner: one wall/goal/player-collision update per frame tick,
// committing the new centre four cycles after the vblank rising edge.
module puck_motion
    import air_hockey_pkg::*;
#(
    parameter coord_s_t X_MIN     = X_MIN_C,
    parameter coord_s_t X_MAX     = X_MAX_C,
    parameter coord_s_t Y_MIN     = Y_MIN_C,
    parameter coord_s_t Y_MAX     = Y_MAX_C,
    parameter coord_s_t PUCK_R    = PUCK_R_C,
    parameter coord_s_t GOAL_Y_LO = GOAL_Y_LO_C,
    parameter coord_s_t GOAL_Y_HI = GOAL_Y_HI_C,
    parameter coord_s_t START_X   = START_X_C,
    parameter coord_s_t START_Y   = START_Y_C,
    parameter vel_t     SERVE_VX  = SERVE_VX_C,
    parameter vel_t     SERVE_VY  = SERVE_VY_C,
    parameter vel_t     VMAX      = VMAX_C
) (
    input  logic          clk_in,
    input  logic          rst,
    puck_motion_if.slave  bus
);
    state_t               state_q, state_d;
    logic                 vblnk_q;
    logic                 tick;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    coord_s_t             nx_q, nx_d;
    coord_s_t             ny_q, ny_d;
    coord_s_t             dx_q, dx_d;
    coord_s_t             dy_q, dy_d;
    vel_t                 vx_q, vx_d;
    vel_t                 vy_q, vy_d;
    logic                 in_play_q, in_play_d;
    logic                 goal_left_q, goal_left_d;
    logic                 goal_right_q, goal_right_d;
    logic                 goal_side_q, goal_side_d;

    coord_s_t             ny_step, nx_step;
    coord_s_t             dx_c, dy_c;
    logic [R_W:0]         r_sum_c;
    logic                 hit;
    vel_t                 hvx_c, hvy_c;

    assign tick    = bus.vblnk_in & ~vblnk_q;
    assign ny_step = $signed({1'b0, y_q}) + coord_s_t'(vy_q);
    assign nx_step = $signed({1'b0, x_q}) + coord_s_t'(vx_q);
    assign dx_c    = nx_q - $signed({1'b0, bus.player_x_in});
    assign dy_c    = ny_q - $signed({1'b0, bus.player_y_in});
    assign r_sum_c = (R_W+1)'(PUCK_R) + {1'b0, bus.player_r_in};
    assign hvx_c   = sat_vel(dx_q >>> 2, VMAX);
    assign hvy_c   = sat_vel(dy_q >>> 2, VMAX);

    // Flag is produced during HIT_APPLY from the operands presented in HIT_CALC.
    circle_hit_check u_hit (
        .clk_in  (clk_in),
        .rst     (rst),
        .dx_i    (dx_c),
        .dy_i    (dy_c),
        .r_sum_i (r_sum_c),
        .hit_o   (hit)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vblnk_q      <= 1'b0;
            x_q          <= START_X[COORD_W-1:0];
            y_q          <= START_Y[COORD_W-1:0];
            nx_q         <= START_X;
            ny_q         <= START_Y;
            dx_q         <= '0;
            dy_q         <= '0;
            vx_q         <= '0;
            vy_q         <= '0;
            in_play_q    <= 1'b0;
            goal_left_q  <= 1'b0;
            goal_right_q <= 1'b0;
            goal_side_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vblnk_q      <= bus.vblnk_in;
            x_q          <= x_d;
            y_q          <= y_d;
            nx_q         <= nx_d;
            ny_q         <= ny_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            in_play_q    <= in_play_d;
            goal_left_q  <= goal_left_d;
            goal_right_q <= goal_right_d;
            goal_side_q  <= goal_side_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        nx_d         = nx_q;
        ny_d         = ny_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        in_play_d    = in_play_q;
        goal_left_d  = 1'b0;
        goal_right_d = 1'b0;
        goal_side_d  = goal_side_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.serve_in) begin
                    vx_d      = SERVE_VX;
                    vy_d      = SERVE_VY;
                    in_play_d = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    state_d = ST_STEP_Y;
                end
            end
            ST_STEP_Y: begin
                ny_d = ny_step;
                if (ny_step - PUCK_R < Y_MIN) begin
                    ny_d = Y_MIN + PUCK_R;
                    vy_d = -vy_q;
                end else if (ny_step + PUCK_R > Y_MAX) begin
                    ny_d = Y_MAX - PUCK_R;
                    vy_d = -vy_q;
                end
                state_d = ST_STEP_X;
            end
            ST_STEP_X: begin
                nx_d    = nx_step;
                state_d = ST_HIT_CALC;
                // Crossing an end wall inside the mouth is a goal; elsewhere it reflects.
                if (nx_step - PUCK_R < X_MIN) begin
                    if (ny_q >= GOAL_Y_LO && ny_q <= GOAL_Y_HI) begin
                        goal_side_d = 1'b0;
                        state_d     = ST_GOAL;
                    end else begin
                        nx_d = X_MIN + PUCK_R;
                        vx_d = -vx_q;
                    end
                end else if (nx_step + PUCK_R > X_MAX) begin
                    if (ny_q >= GOAL_Y_LO && ny_q <= GOAL_Y_HI) begin
                        goal_side_d = 1'b1;
                        state_d     = ST_GOAL;
                    end else begin
                        nx_d = X_MAX - PUCK_R;
                        vx_d = -vx_q;
                    end
                end
            end
            ST_HIT_CALC: begin
                dx_d    = dx_c;
                dy_d    = dy_c;
                state_d = ST_HIT_APPLY;
            end
            ST_HIT_APPLY: begin
                if (hit) begin
                    vx_d = hvx_c;
                    vy_d = hvy_c;
                    if (hvx_c == '0 && hvy_c == '0) begin
                        vx_d = 5'sd1;
                    end
                end
                x_d     = nx_q[COORD_W-1:0];
                y_d     = ny_q[COORD_W-1:0];
                state_d = ST_WAIT;
            end
            ST_GOAL: begin
                goal_left_d  = ~goal_side_q;
                goal_right_d = goal_side_q;
                x_d          = START_X[COORD_W-1:0];
                y_d          = START_Y[COORD_W-1:0];
                vx_d         = '0;
                vy_d         = '0;
                in_play_d    = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.xpos_out   = x_q;
    assign bus.ypos_out   = y_q;
    assign bus.goal_left  = goal_left_q;
    assign bus.goal_right = goal_right_q;
    assign bus.in_play    = in_play_q;
endmodule

// File: tb/tb_puck_motion.sv
// Randomised frame-by-frame bench for puck_motion against a per-frame arithmetic model.
module tb_puck_motion;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    puck_motion_if bus();

    puck_motion dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: puck centre, velocity and play flag after the last frame.
    int m_x, m_y, m_vx, m_vy;
    bit m_play;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int sat7(input int v);
        if (v > 7) return 7;
        if (v < -7) return -7;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 512; m_y = 384; m_vx = 0; m_vy = 0; m_play = 0;
    endtask

    task automatic drive_junk_player();
        bus.player_x_in = 12'($urandom_range(0, 4095));
        bus.player_y_in = 12'($urandom_range(0, 4095));
        bus.player_r_in = 8'($urandom_range(0, 255));
    endtask

    task automatic do_serve();
        @(negedge clk);
        bus.serve_in = 1'b1;
        @(negedge clk);
        bus.serve_in = 1'b0;
        if (!m_play) begin
            m_play = 1; m_vx = 3; m_vy = 2;
        end
        check_eq("serve_in_play", int'(bus.in_play), int'(m_play));
        $display("serve: in_play=%0d vx=%0d vy=%0d", m_play, m_vx, m_vy);
    endtask

    task automatic run_frame(input int fno, input bit glitch, input bit force_far);
        int nx, ny, nvx, nvy, goal, px, py, pr, old_x, old_y, gl, gr, mode, dx, dy;
        old_x = m_x; old_y = m_y;
        nx = m_x; ny = m_y; nvx = m_vx; nvy = m_vy; goal = 0; gl = 0; gr = 0;
        if (m_play) begin
            ny = m_y + m_vy;
            if (ny - 12 < 32) begin ny = 44; nvy = -nvy; end
            else if (ny + 12 > 735) begin ny = 723; nvy = -nvy; end
            nx = m_x + m_vx;
            if (nx - 12 < 32) begin
                if (ny >= 288 && ny <= 479) goal = 1;
                else begin nx = 44; nvx = -nvx; end
            end else if (nx + 12 > 991) begin
                if (ny >= 288 && ny <= 479) goal = 2;
                else begin nx = 979; nvx = -nvx; end
            end
        end
        mode = $urandom_range(0, 7);
        if (!m_play || force_far || mode >= 3) begin
            px = $urandom_range(0, 4095); py = $urandom_range(0, 4095); pr = $urandom_range(0, 30);
        end else if (mode == 0) begin
            // Player just beside the puck, nudging it back toward the centre line.
            px = ($urandom_range(0, 1) == 1) ? nx + 20 : nx - 20;
            py = ny + (ny - 384) / 8;
            pr = 60;
        end else begin
            px = nx + $urandom_range(0, 60) - 30;
            py = ny + $urandom_range(0, 60) - 30;
            pr = $urandom_range(0, 40);
        end
        if (m_play && goal == 0) begin
            dx = nx - px; dy = ny - py;
            if (dx * dx + dy * dy <= (12 + pr) * (12 + pr)) begin
                nvx = sat7(dx >>> 2); nvy = sat7(dy >>> 2);
                if (nvx == 0 && nvy == 0) nvx = 1;
            end
        end
        if (goal != 0) begin
            model_reset();
        end else if (m_play) begin
            m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy;
        end

        @(negedge clk);
        bus.vblnk_in = 1'b1;
        drive_junk_player();
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (bus.goal_left)  gl++;
            if (bus.goal_right) gr++;
            if (k == 1) begin
                bus.player_x_in = 12'(px); bus.player_y_in = 12'(py); bus.player_r_in = 8'(pr);
            end
            if (k == 2 && glitch) bus.vblnk_in = 1'b0;
            if (k == 3 && glitch) bus.vblnk_in = 1'b1;
            if (k == 3) begin
                check_eq("hold_x", int'(bus.xpos_out), old_x);
                check_eq("hold_y", int'(bus.ypos_out), old_y);
            end
            if (k == 4) begin
                if (goal == 0) check_eq("latency_x", int'(bus.xpos_out), old_x);
                drive_junk_player();
            end
            if (k == 5) begin
                check_eq("new_x", int'(bus.xpos_out), m_x);
                check_eq("new_y", int'(bus.ypos_out), m_y);
            end
            if (k == 8) bus.vblnk_in = 1'b0;
        end
        check_eq("final_x", int'(bus.xpos_out), m_x);
        check_eq("in_play", int'(bus.in_play), int'(m_play));
        check_eq("goal_left_cycles", gl, (goal == 1) ? 1 : 0);
        check_eq("goal_right_cycles", gr, (goal == 2) ? 1 : 0);
        $display("frame %0d: x=%0d y=%0d vx=%0d vy=%0d player=(%0d,%0d,r%0d) goal=%0d glitch=%0d",
                 fno, m_x, m_y, m_vx, m_vy, px, py, pr, goal, glitch);
    endtask

    initial begin
        rst = 1'b1;
        bus.vblnk_in = 1'b0;
        bus.serve_in = 1'b0;
        bus.player_x_in = 12'd4000;
        bus.player_y_in = 12'd4000;
        bus.player_r_in = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_x", int'(bus.xpos_out), 512);
        check_eq("reset_y", int'(bus.ypos_out), 384);
        check_eq("reset_in_play", int'(bus.in_play), 0);
        check_eq("reset_goal_l", int'(bus.goal_left), 0);
        check_eq("reset_goal_r", int'(bus.goal_right), 0);

        for (int i = 0; i < 3; i++) run_frame(i, 1'b0, 1'b1);

        do_serve();
        run_frame(3, 1'b0, 1'b1);
        check_eq("serve_frame_x", int'(bus.xpos_out), 515);
        check_eq("serve_frame_y", int'(bus.ypos_out), 386);

        for (int i = 4; i < 604; i++) begin
            if (!m_play && $urandom_range(0, 1) == 1) do_serve();
            else if (m_play && $urandom_range(0, 7) == 0) do_serve();
            run_frame(i, $urandom_range(0, 3) == 0, 1'b0);
        end

        // Reset in the middle of a frame update.
        if (!m_play) do_serve();
        @(negedge clk);
        bus.vblnk_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_x", int'(bus.xpos_out), 512);
        check_eq("midrst_y", int'(bus.ypos_out), 384);
        check_eq("midrst_in_play", int'(bus.in_play), 0);
        check_eq("midrst_goal_l", int'(bus.goal_left), 0);
        check_eq("midrst_goal_r", int'(bus.goal_right), 0);
        rst = 1'b0;
        bus.vblnk_in = 1'b0;
        model_reset();
        $display("mid-frame reset applied");
        run_frame(604, 1'b0, 1'b0);
        run_frame(605, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
